// File: rtl/pcm_sample_fifo.sv
// First-word-fall-through buffer for PCM samples captured by i2s_master.
// Presents sign-extended samples with L/R tags, counts overflow drops, flags L/R alternation breaks.
module pcm_sample_fifo #(
  parameter int unsigned PCM_PRECISION = 18,
  parameter int unsigned OUT_WIDTH     = 24,
  parameter int unsigned DEPTH         = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [PCM_PRECISION-1:0] fifo_din,
  input  logic                     fifo_chan,
  input  logic                     fifo_w_stb,
  output logic                     fifo_full,
  output logic [OUT_WIDTH-1:0]     m_data,
  output logic                     m_chan,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              drop_count,
  input  logic                     drop_clr,
  output logic                     chan_err,
  input  logic                     chan_err_clr
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned LVL_W   = PTR_W + 1;
  localparam int unsigned ENTRY_W = PCM_PRECISION + 1;

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             full_q, full_d;
  logic             valid_q, valid_d;
  logic [15:0]      drop_q, drop_d;
  logic             err_q, err_d;
  logic             last_vld_q, last_vld_d;
  logic             last_chan_q, last_chan_d;

  logic             wr_acc;
  logic             rd_acc;
  logic [ENTRY_W-1:0] head;

  // Next-state logic; full/valid are registered copies of the next level.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    drop_d      = drop_q;
    err_d       = err_q;
    last_vld_d  = last_vld_q;
    last_chan_d = last_chan_q;

    wr_acc = fifo_w_stb && !full_q;
    rd_acc = valid_q && m_ready;

    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    unique case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    full_d  = (level_d == LVL_W'(DEPTH));
    valid_d = (level_d != '0);

    // A drop in the same cycle as a clear leaves exactly one recorded drop.
    if (fifo_w_stb && full_q) begin
      if (drop_clr)                drop_d = 16'd1;
      else if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
    end else if (drop_clr) begin
      drop_d = 16'd0;
    end

    if (wr_acc && last_vld_q && (fifo_chan == last_chan_q)) err_d = 1'b1;
    else if (chan_err_clr)                                   err_d = 1'b0;

    if (wr_acc) begin
      last_vld_d  = 1'b1;
      last_chan_d = fifo_chan;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      full_q      <= 1'b0;
      valid_q     <= 1'b0;
      drop_q      <= '0;
      err_q       <= 1'b0;
      last_vld_q  <= 1'b0;
      last_chan_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      full_q      <= full_d;
      valid_q     <= valid_d;
      drop_q      <= drop_d;
      err_q       <= err_d;
      last_vld_q  <= last_vld_d;
      last_chan_q <= last_chan_d;
    end
  end

  // Sample storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= {fifo_chan, fifo_din};
  end

  assign head       = mem_q[rd_ptr_q];
  assign m_chan     = head[ENTRY_W-1];
  assign m_data     = OUT_WIDTH'($signed(head[PCM_PRECISION-1:0]));
  assign m_valid    = valid_q;
  assign fifo_full  = full_q;
  assign level      = level_q;
  assign drop_count = drop_q;
  assign chan_err   = err_q;

endmodule
